// File: rtl/gmii_rx_frame_parser.sv
// GMII receive frame parser: strips preamble/SFD, checks CRC-32 and length,
// drops the FCS and streams payload with sof/eof, per-frame status and stats.
module gmii_rx_frame_parser #(
    parameter int unsigned MIN_FRAME = 64,
    parameter int unsigned MAX_FRAME = 1518,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             gmii_rx_clk,
    input  logic             reset,
    input  logic [7:0]       gmii_rxd,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_sof,
    output logic             rx_eof,
    output logic             rx_good,
    output logic             rx_bad,
    output logic [2:0]       rx_err_code,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam int unsigned LEN_W   = $clog2(MAX_FRAME + 2);
    localparam int unsigned DLY_LEN = 5;

    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_FRAME);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_FRAME + 1);
    localparam logic [LEN_W-1:0] LEN_DLY = LEN_W'(DLY_LEN);

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP
    } state_t;

    state_t state, state_nxt;

    logic [31:0]              crc, crc_nxt;
    logic [LEN_W-1:0]         cnt, cnt_nxt;
    logic                     phy_err, phy_err_nxt;
    logic [DLY_LEN-1:0][7:0]  dly, dly_nxt;

    logic [7:0]       data_nxt;
    logic             valid_nxt, sof_nxt, eof_nxt, good_nxt, bad_nxt;
    logic [2:0]       code_nxt;
    logic [CNT_W-1:0] good_cnt_nxt, bad_cnt_nxt;

    logic [31:0] crc_upd_c;
    logic        len_err_c, crc_err_c;
    logic [2:0]  err_code_c;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign crc_upd_c  = crc_byte(crc, gmii_rxd);
    assign len_err_c  = (cnt < LEN_MIN) || (cnt > LEN_MAX);
    assign crc_err_c  = (crc != CRC_RESIDUE);
    assign err_code_c = {phy_err | gmii_rx_er, len_err_c, crc_err_c};

    always_ff @(posedge gmii_rx_clk) begin
        if (reset) begin
            state <= S_WAIT_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        crc_nxt      = crc;
        cnt_nxt      = cnt;
        phy_err_nxt  = phy_err;
        dly_nxt      = dly;
        data_nxt     = 8'h00;
        valid_nxt    = 1'b0;
        sof_nxt      = 1'b0;
        eof_nxt      = 1'b0;
        good_nxt     = 1'b0;
        bad_nxt      = 1'b0;
        code_nxt     = 3'b000;
        good_cnt_nxt = good_cnt;
        bad_cnt_nxt  = bad_cnt;

        case (state)
            S_WAIT_IDLE: begin
                if (!gmii_rx_dv) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (gmii_rx_dv) begin
                    state_nxt = (gmii_rxd == PRE_BYTE) ? S_PREAMBLE : S_DROP;
                end
            end
            S_PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_nxt = S_IDLE;
                end else if (gmii_rxd == SFD_BYTE) begin
                    state_nxt   = S_DATA;
                    crc_nxt     = CRC_INIT;
                    cnt_nxt     = '0;
                    phy_err_nxt = 1'b0;
                end else if (gmii_rxd != PRE_BYTE) begin
                    state_nxt = S_DROP;
                end
            end
            S_DATA: begin
                // Oldest delay-line entry is the byte five positions back.
                if (gmii_rx_dv) begin
                    cnt_nxt = (cnt == LEN_SAT) ? cnt : cnt + LEN_W'(1);
                    crc_nxt = crc_upd_c;
                    dly_nxt = {dly[DLY_LEN-2:0], gmii_rxd};
                    if (gmii_rx_er) phy_err_nxt = 1'b1;
                    if (cnt >= LEN_DLY) begin
                        valid_nxt = 1'b1;
                        data_nxt  = dly[DLY_LEN-1];
                        sof_nxt   = (cnt == LEN_DLY);
                    end
                end else begin
                    state_nxt = S_IDLE;
                    code_nxt  = err_code_c;
                    good_nxt  = (err_code_c == 3'b000);
                    bad_nxt   = (err_code_c != 3'b000);
                    if (err_code_c == 3'b000) begin
                        if (good_cnt != '1) good_cnt_nxt = good_cnt + CNT_W'(1);
                    end else begin
                        if (bad_cnt != '1) bad_cnt_nxt = bad_cnt + CNT_W'(1);
                    end
                    if (cnt >= LEN_DLY) begin
                        valid_nxt = 1'b1;
                        eof_nxt   = 1'b1;
                        data_nxt  = dly[DLY_LEN-1];
                        sof_nxt   = (cnt == LEN_DLY);
                    end
                end
            end
            S_DROP: begin
                if (!gmii_rx_dv) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (reset) begin
            crc         <= '0;
            cnt         <= '0;
            phy_err     <= 1'b0;
            dly         <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_sof      <= 1'b0;
            rx_eof      <= 1'b0;
            rx_good     <= 1'b0;
            rx_bad      <= 1'b0;
            rx_err_code <= '0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
        end else begin
            crc         <= crc_nxt;
            cnt         <= cnt_nxt;
            phy_err     <= phy_err_nxt;
            dly         <= dly_nxt;
            rx_data     <= data_nxt;
            rx_valid    <= valid_nxt;
            rx_sof      <= sof_nxt;
            rx_eof      <= eof_nxt;
            rx_good     <= good_nxt;
            rx_bad      <= bad_nxt;
            rx_err_code <= code_nxt;
            good_cnt    <= good_cnt_nxt;
            bad_cnt     <= bad_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_parser.sv
// Bench for gmii_rx_frame_parser: random frames scored against a frame-level
// model of the expected payload beats, status codes and statistics.
module tb_gmii_rx_frame_parser;

    localparam int unsigned MIN_FRAME = 64;
    localparam int unsigned MAX_FRAME = 1518;
    localparam int unsigned CNT_W     = 16;

    logic             gmii_rx_clk;
    logic             reset;
    logic [7:0]       gmii_rxd;
    logic             gmii_rx_dv;
    logic             gmii_rx_er;
    logic [7:0]       rx_data;
    logic             rx_valid, rx_sof, rx_eof, rx_good, rx_bad;
    logic [2:0]       rx_err_code;
    logic [CNT_W-1:0] good_cnt, bad_cnt;

    gmii_rx_frame_parser #(
        .MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME), .CNT_W(CNT_W)
    ) dut (
        .gmii_rx_clk(gmii_rx_clk), .reset(reset),
        .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .rx_good(rx_good), .rx_bad(rx_bad), .rx_err_code(rx_err_code),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       valid, sof, eof, good, bad;
        logic [2:0] code;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      act_q[$];
    logic [7:0] frame_q[$];
    logic [7:0] pre_q[$];
    int         checks = 0;
    int         passed = 0;
    int         good_exp = 0;
    int         bad_exp = 0;

    initial gmii_rx_clk = 1'b0;
    always #4 gmii_rx_clk = ~gmii_rx_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "watchdog");
    end

    // Everything the block reports, captured away from the active edge.
    always @(negedge gmii_rx_clk) begin
        if (rx_valid || rx_sof || rx_eof || rx_good || rx_bad) begin
            act_q.push_back('{data: rx_valid ? rx_data : 8'h00, valid: rx_valid,
                              sof: rx_sof, eof: rx_eof, good: rx_good,
                              bad: rx_bad, code: rx_err_code});
        end
    end

    task automatic drive(input logic dv, input logic [7:0] d, input logic er, input logic rst);
        @(posedge gmii_rx_clk);
        #1;
        gmii_rx_dv = dv;
        gmii_rxd   = d;
        gmii_rx_er = er;
        reset      = rst;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic std_preamble();
        pre_q.delete();
        repeat (7) pre_q.push_back(8'h55);
        pre_q.push_back(8'hD5);
    endtask

    // Standard Ethernet FCS over the first m bytes of frame_q, bitwise.
    function automatic logic [31:0] fcs_of(input int m);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < m; i++) begin
            for (int b = 0; b < 8; b++) begin
                logic fb = frame_q[i][b] ^ c[0];
                c = {1'b0, c[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0);
            end
        end
        return ~c;
    endfunction

    task automatic make_frame(input int n, input bit corrupt);
        logic [31:0] f;
        frame_q.delete();
        if (n < 4) begin
            for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
        end else begin
            for (int i = 0; i < n - 4; i++) frame_q.push_back(8'($urandom));
            f = fcs_of(n - 4);
            for (int i = 0; i < 4; i++) frame_q.push_back(f[8*i +: 8]);
            if (corrupt) frame_q[n-1] = frame_q[n-1] ^ 8'h08;
        end
    endtask

    // Expected beats for a whole frame of frame_q: payload = all but last 4 bytes.
    task automatic model_frame(input int er_idx);
        int         n = frame_q.size();
        logic       crc_err, len_err, phy;
        logic [2:0] code;
        crc_err = 1'b1;
        if (n >= 4) crc_err = ({frame_q[n-1], frame_q[n-2], frame_q[n-3], frame_q[n-4]} != fcs_of(n - 4));
        len_err = (n < MIN_FRAME) || (n > MAX_FRAME);
        phy     = (er_idx >= 0) && (er_idx < n);
        code    = {phy, len_err, crc_err};
        if (n >= 5) begin
            for (int i = 0; i <= n - 5; i++) begin
                exp_q.push_back('{data: frame_q[i], valid: 1'b1, sof: (i == 0),
                                  eof: (i == n - 5), good: (i == n - 5) && (code == 0),
                                  bad: (i == n - 5) && (code != 0),
                                  code: (i == n - 5) ? code : 3'b000});
            end
        end else begin
            exp_q.push_back('{data: 8'h00, valid: 1'b0, sof: 1'b0, eof: 1'b0,
                              good: 1'b0, bad: 1'b1, code: code});
        end
        if (code == 0) good_exp++;
        else bad_exp++;
    endtask

    task automatic send_frame(input int er_idx, input int rst_idx, input int gap);
        foreach (pre_q[i]) drive(1'b1, pre_q[i], 1'b0, 1'b0);
        foreach (frame_q[i]) drive(1'b1, frame_q[i], 1'b1 && (i == er_idx), 1'b1 && (i == rst_idx));
        idle(gap);
    endtask

    task automatic test_reset();
        gmii_rx_dv = 1'b0; gmii_rxd = 8'h00; gmii_rx_er = 1'b0; reset = 1'b1;
        repeat (3) @(posedge gmii_rx_clk);
        @(negedge gmii_rx_clk);
        checks++;
        if ({rx_valid, rx_sof, rx_eof, rx_good, rx_bad} !== 5'b0)
            $display("FAIL reset_flags: got %b required 00000", {rx_valid, rx_sof, rx_eof, rx_good, rx_bad});
        else passed++;
        checks++;
        if ({rx_data, rx_err_code} !== 11'h0)
            $display("FAIL reset_data_code: got %h/%b required 00/000", rx_data, rx_err_code);
        else passed++;
        checks++;
        if ({good_cnt, bad_cnt} !== '0)
            $display("FAIL reset_counters: got %0d/%0d required 0/0", good_cnt, bad_cnt);
        else passed++;
        idle(2);
        act_q.delete();
    endtask

    task automatic test_good_frame();
        exp_q.delete(); act_q.delete(); std_preamble();
        make_frame(64, 1'b0); model_frame(-1); send_frame(-1, -1, 1); idle(4);
        checks++;
        if (act_q.size() != exp_q.size()) $display("FAIL good_frame beats: got %0d required %0d", act_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) $display("FAIL good_frame beat %0d: got %h required %h", i, act_q[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (good_cnt !== CNT_W'(good_exp) || bad_cnt !== CNT_W'(bad_exp))
            $display("FAIL good_frame counters: got %0d/%0d required %0d/%0d", good_cnt, bad_cnt, good_exp, bad_exp);
        else passed++;
    endtask

    task automatic test_errors();
        exp_q.delete(); act_q.delete(); std_preamble();
        make_frame(64, 1'b1); model_frame(-1); send_frame(-1, -1, 2);
        make_frame(40, 1'b0); model_frame(-1); send_frame(-1, -1, 2);
        make_frame(3, 1'b0);  model_frame(-1); send_frame(-1, -1, 2);
        make_frame(64, 1'b0); model_frame(19); send_frame(19, -1, 2);
        make_frame(64, 1'b1); model_frame(19); send_frame(19, -1, 2);
        idle(4);
        checks++;
        if (act_q.size() != exp_q.size()) $display("FAIL errors beats: got %0d required %0d", act_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) $display("FAIL errors beat %0d: got %h required %h", i, act_q[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (good_cnt !== CNT_W'(good_exp) || bad_cnt !== CNT_W'(bad_exp))
            $display("FAIL errors counters: got %0d/%0d required %0d/%0d", good_cnt, bad_cnt, good_exp, bad_exp);
        else passed++;
    endtask

    task automatic test_drop();
        exp_q.delete(); act_q.delete();
        make_frame(64, 1'b0);
        pre_q.delete();
        pre_q.push_back(8'h55); pre_q.push_back(8'h57);
        repeat (5) pre_q.push_back(8'h55);
        pre_q.push_back(8'hD5);
        send_frame(-1, -1, 2);
        pre_q.delete(); pre_q.push_back(8'hD5);
        send_frame(-1, -1, 2);
        idle(4);
        checks++;
        if (act_q.size() != 0) $display("FAIL drop beats: got %0d required 0", act_q.size());
        else passed++;
        checks++;
        if (good_cnt !== CNT_W'(good_exp) || bad_cnt !== CNT_W'(bad_exp))
            $display("FAIL drop counters: got %0d/%0d required %0d/%0d", good_cnt, bad_cnt, good_exp, bad_exp);
        else passed++;
    endtask

    task automatic test_back_to_back();
        exp_q.delete(); act_q.delete(); std_preamble();
        make_frame(64, 1'b0); model_frame(-1); send_frame(-1, -1, 1);
        make_frame(64, 1'b0); model_frame(-1); send_frame(-1, -1, 1);
        idle(4);
        checks++;
        if (act_q.size() != exp_q.size()) $display("FAIL back_to_back beats: got %0d required %0d", act_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) $display("FAIL back_to_back beat %0d: got %h required %h", i, act_q[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (good_cnt !== CNT_W'(good_exp)) $display("FAIL back_to_back good_cnt: got %0d required %0d", good_cnt, good_exp);
        else passed++;
    endtask

    task automatic test_boundaries();
        int lens[6] = '{0, 4, 5, 1518, 1519, 1530};
        exp_q.delete(); act_q.delete(); std_preamble();
        foreach (lens[k]) begin
            make_frame(lens[k], 1'b0); model_frame(-1); send_frame(-1, -1, 1 + k % 2);
        end
        idle(4);
        checks++;
        if (act_q.size() != exp_q.size()) $display("FAIL boundaries beats: got %0d required %0d", act_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) $display("FAIL boundaries beat %0d: got %h required %h", i, act_q[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (good_cnt !== CNT_W'(good_exp) || bad_cnt !== CNT_W'(bad_exp))
            $display("FAIL boundaries counters: got %0d/%0d required %0d/%0d", good_cnt, bad_cnt, good_exp, bad_exp);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int r = 29;
        exp_q.delete(); act_q.delete(); std_preamble();
        make_frame(64, 1'b0);
        // Bytes sampled before the reset edge still emerge; nothing after.
        for (int i = 0; i <= r - 6; i++)
            exp_q.push_back('{data: frame_q[i], valid: 1'b1, sof: (i == 0), eof: 1'b0,
                              good: 1'b0, bad: 1'b0, code: 3'b000});
        send_frame(-1, r, 2);
        good_exp = 0; bad_exp = 0;
        checks++;
        if (good_cnt !== '0 || bad_cnt !== '0)
            $display("FAIL reset_mid counters_cleared: got %0d/%0d required 0/0", good_cnt, bad_cnt);
        else passed++;
        make_frame(64, 1'b0); model_frame(-1); send_frame(-1, -1, 1);
        idle(4);
        checks++;
        if (act_q.size() != exp_q.size()) $display("FAIL reset_mid beats: got %0d required %0d", act_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) $display("FAIL reset_mid beat %0d: got %h required %h", i, act_q[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (good_cnt !== CNT_W'(1)) $display("FAIL reset_mid good_cnt: got %0d required 1", good_cnt);
        else passed++;
    endtask

    task automatic test_random();
        int n, er;
        exp_q.delete(); act_q.delete(); std_preamble();
        for (int f = 0; f < 24; f++) begin
            case ($urandom_range(0, 3))
                0:       n = $urandom_range(0, 8);
                1:       n = $urandom_range(62, 66);
                2:       n = $urandom_range(20, 130);
                default: n = 64;
            endcase
            make_frame(n, ($urandom_range(0, 3) == 0));
            er = ($urandom_range(0, 5) == 0 && n > 0) ? $urandom_range(0, n - 1) : -1;
            model_frame(er);
            send_frame(er, -1, $urandom_range(1, 3));
        end
        idle(4);
        checks++;
        if (act_q.size() != exp_q.size()) $display("FAIL random beats: got %0d required %0d", act_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) $display("FAIL random beat %0d: got %h required %h", i, act_q[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (good_cnt !== CNT_W'(good_exp) || bad_cnt !== CNT_W'(bad_exp))
            $display("FAIL random counters: got %0d/%0d required %0d/%0d", good_cnt, bad_cnt, good_exp, bad_exp);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_errors();
        test_drop();
        test_back_to_back();
        test_boundaries();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
